spi_mem_arbiter: RTL

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

---
 rtl/spi_mem_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_arbiter.sv
// Three-way arbiter sharing one SPI mode-0 serial SRAM between fetch, data and debug.
// Define DEBUG_PORT_EN to let the debug requester take part in arbitration.
module spi_mem_arbiter #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02,
  parameter int         IDLE_GAP  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [14:0] fetch_addr,
  output logic        fetch_ack,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [14:0] data_addr,
  input  logic [15:0] data_wdata,
  output logic        data_ack,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [14:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        mem_csb_o,
  output logic        mem_sclk_o,
  output logic        mem_out_o,
  input  logic        mem_in_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4,
    GAP  = 3'd5
  } state_t;

  localparam logic [1:0] ID_FETCH = 2'd0;
  localparam logic [1:0] ID_DATA  = 2'd1;
  localparam logic [1:0] ID_DBG   = 2'd2;

  state_t      state_r;
  logic [1:0]  id_r;
  logic        we_r;
  logic [39:0] sh_r;
  logic [5:0]  bit_cnt_r;
  logic        phase_r;
  logic [15:0] rx_r;
  logic [15:0] gap_r;
  logic        csb_r;
  logic        sclk_r;
  logic        mosi_r;
  logic        fetch_ack_r;
  logic        data_ack_r;
  logic        dbg_ack_r;
  logic        busy_r;
  logic [15:0] rdata_r;

  logic        dbg_sel;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic        gnt_we;
  logic [14:0] gnt_addr;
  logic [15:0] gnt_wdata;
  logic [39:0] gnt_frame;

`ifdef DEBUG_PORT_EN
  assign dbg_sel = dbg_req;
`else
  logic unused_dbg;
  assign dbg_sel    = 1'b0;
  assign unused_dbg = dbg_req;
`endif

  // Fixed-priority selection of the requester to be granted from IDLE.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ID_FETCH;
    gnt_we    = 1'b0;
    gnt_addr  = 15'h0000;
    gnt_wdata = 16'h0000;
    if (dbg_sel) begin
      gnt_valid = 1'b1;
      gnt_id    = ID_DBG;
      gnt_we    = dbg_we;
      gnt_addr  = dbg_addr;
      gnt_wdata = dbg_wdata;
    end else if (data_req) begin
      gnt_valid = 1'b1;
      gnt_id    = ID_DATA;
      gnt_we    = data_we;
      gnt_addr  = data_addr;
      gnt_wdata = data_wdata;
    end else if (fetch_req) begin
      gnt_valid = 1'b1;
      gnt_id    = ID_FETCH;
      gnt_we    = 1'b0;
      gnt_addr  = fetch_addr;
      gnt_wdata = 16'h0000;
    end else begin
      gnt_valid = 1'b0;
    end
  end

  // Reads shift zeros during the data phase, so the data field is cleared for them.
  assign gnt_frame = {(gnt_we ? CMD_WRITE : CMD_READ), gnt_addr, 1'b0,
                      (gnt_we ? gnt_wdata : 16'h0000)};

  // Transaction sequencer: grant, 40 serial bits at 2 clocks each, done pulse, gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      id_r        <= ID_FETCH;
      we_r        <= 1'b0;
      sh_r        <= 40'h0;
      bit_cnt_r   <= 6'd0;
      phase_r     <= 1'b0;
      rx_r        <= 16'h0000;
      gap_r       <= 16'h0000;
      csb_r       <= 1'b1;
      sclk_r      <= 1'b0;
      mosi_r      <= 1'b0;
      fetch_ack_r <= 1'b0;
      data_ack_r  <= 1'b0;
      dbg_ack_r   <= 1'b0;
      busy_r      <= 1'b0;
      rdata_r     <= 16'h0000;
    end else begin
      fetch_ack_r <= 1'b0;
      data_ack_r  <= 1'b0;
      dbg_ack_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (gnt_valid) begin
            state_r   <= CMD;
            id_r      <= gnt_id;
            we_r      <= gnt_we;
            mosi_r    <= gnt_frame[39];
            sh_r      <= {gnt_frame[38:0], 1'b0};
            bit_cnt_r <= 6'd0;
            phase_r   <= 1'b0;
            csb_r     <= 1'b0;
            sclk_r    <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        CMD, ADDR, DATA: begin
          if (!phase_r) begin
            sclk_r  <= 1'b1;
            phase_r <= 1'b1;
          end else begin
            sclk_r  <= 1'b0;
            phase_r <= 1'b0;
            rx_r    <= {rx_r[14:0], mem_in_i};
            if (bit_cnt_r == 6'd39) begin
              state_r <= DONE;
              csb_r   <= 1'b1;
              mosi_r  <= 1'b0;
              if (!we_r) begin
                rdata_r <= {rx_r[14:0], mem_in_i};
              end else begin
                rdata_r <= rdata_r;
              end
              case (id_r)
                ID_FETCH: fetch_ack_r <= 1'b1;
                ID_DATA:  data_ack_r  <= 1'b1;
                ID_DBG:   dbg_ack_r   <= 1'b1;
                default:  fetch_ack_r <= 1'b0;
              endcase
            end else begin
              bit_cnt_r <= bit_cnt_r + 6'd1;
              mosi_r    <= sh_r[39];
              sh_r      <= {sh_r[38:0], 1'b0};
              if (bit_cnt_r == 6'd7) begin
                state_r <= ADDR;
              end else if (bit_cnt_r == 6'd23) begin
                state_r <= DATA;
              end else begin
                state_r <= state_r;
              end
            end
          end
        end
        DONE: begin
          if (IDLE_GAP > 1) begin
            state_r <= GAP;
            gap_r   <= 16'(IDLE_GAP - 2);
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        GAP: begin
          if (gap_r == 16'h0000) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            gap_r   <= gap_r - 16'h0001;
          end
        end
        default: begin
          state_r <= IDLE;
          csb_r   <= 1'b1;
          sclk_r  <= 1'b0;
          mosi_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_ack  = fetch_ack_r;
  assign data_ack   = data_ack_r;
  assign dbg_ack    = dbg_ack_r;
  assign rdata      = rdata_r;
  assign busy       = busy_r;
  assign mem_csb_o  = csb_r;
  assign mem_sclk_o = sclk_r;
  assign mem_out_o  = mosi_r;

endmodule
